// File: rtl/rr_switch_alloc_if.sv
// Request/grant bundle between the router input stages and the
// switch allocator; master drives requests, slave returns grants.
interface rr_switch_alloc_if;
   logic [4:0]  req_valid;
   logic [14:0] req_dir;
   logic [4:0]  req_tail;
   logic [2:0]  ans_R;
   logic [2:0]  ans_L;
   logic [2:0]  ans_U;
   logic [2:0]  ans_D;
   logic [2:0]  ans_EJ;
   logic [4:0]  gnt;
   logic [4:0]  lock_busy;

   modport master (
      output req_valid, req_dir, req_tail,
      input  ans_R, ans_L, ans_U, ans_D, ans_EJ,
      input  gnt, lock_busy
   );

   modport slave (
      input  req_valid, req_dir, req_tail,
      output ans_R, ans_L, ans_U, ans_D, ans_EJ,
      output gnt, lock_busy
   );
endinterface

// File: rtl/rr_switch_alloc.sv
// 5x5 round-robin switch allocator with wormhole output locking.
// Optional idle-lock force release: define SA_LOCK_TIMEOUT_EN.
module rr_switch_alloc #(
   parameter int unsigned TIMEOUT = 15
) (
   input logic             clk,
   input logic             reset,
   rr_switch_alloc_if.slave sa
);

   localparam int N = 5;
   localparam logic [2:0] NONE = 3'd7;

   typedef enum logic {
      IDLE,
      LOCKED
   } state_t;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..255");
   end

   state_t     st_q    [N];
   state_t     st_d    [N];
   logic [2:0] owner_q [N];
   logic [2:0] owner_d [N];
   logic [2:0] ptr_q   [N];
   logic [2:0] ptr_d   [N];
   logic [2:0] ans_q   [N];
   logic [2:0] ans_d   [N];
   logic [4:0] gnt_q;
   logic [4:0] gnt_d;
   logic [4:0] busy_q;
   logic [4:0] busy_d;
   logic [4:0] reqm    [N];

`ifdef SA_LOCK_TIMEOUT_EN
   logic [7:0] cnt_q   [N];
   logic [7:0] cnt_d   [N];
`endif

   function automatic logic [2:0] inc5(input logic [2:0] x);
      return (x == 3'd4) ? 3'd0 : x + 3'd1;
   endfunction

   // Illegal codes 5..7 never match an output, so they drop out here.
   always_comb begin
      for (int o = 0; o < N; o++) begin
         for (int i = 0; i < N; i++) begin
            reqm[o][i] = sa.req_valid[i] &&
                         (sa.req_dir[3*i +: 3] == 3'(o));
         end
      end
   end

   always_comb begin
      logic       found;
      logic [2:0] win;
      logic [2:0] own;
      logic [3:0] idx;
      gnt_d  = '0;
      busy_d = '0;
      for (int o = 0; o < N; o++) begin
         st_d[o]    = st_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         ans_d[o]   = NONE;
`ifdef SA_LOCK_TIMEOUT_EN
         cnt_d[o]   = cnt_q[o];
`endif
         found = 1'b0;
         win   = '0;
         own   = owner_q[o];
         idx   = '0;
         for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr_q[o]} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && reqm[o][idx[2:0]]) begin
               found = 1'b1;
               win   = idx[2:0];
            end
         end
         unique case (st_q[o])
            IDLE: begin
               if (found) begin
                  ans_d[o]   = win;
                  gnt_d[win] = 1'b1;
                  ptr_d[o]   = inc5(win);
                  if (!sa.req_tail[win]) begin
                     owner_d[o] = win;
                     st_d[o]    = LOCKED;
`ifdef SA_LOCK_TIMEOUT_EN
                     cnt_d[o]   = '0;
`endif
                  end
               end
            end
            LOCKED: begin
               if (reqm[o][own]) begin
                  ans_d[o]   = own;
                  gnt_d[own] = 1'b1;
`ifdef SA_LOCK_TIMEOUT_EN
                  cnt_d[o]   = '0;
`endif
                  if (sa.req_tail[own]) st_d[o] = IDLE;
               end else begin
`ifdef SA_LOCK_TIMEOUT_EN
                  // Stalled owner: give the output back, next in line first.
                  if (cnt_q[o] + 8'd1 == 8'(TIMEOUT)) begin
                     st_d[o]  = IDLE;
                     ptr_d[o] = inc5(own);
                     cnt_d[o] = '0;
                  end else begin
                     cnt_d[o] = cnt_q[o] + 8'd1;
                  end
`endif
               end
            end
            default: st_d[o] = IDLE;
         endcase
         busy_d[o] = (st_d[o] == LOCKED);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int o = 0; o < N; o++) begin
            st_q[o]    <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
            ans_q[o]   <= NONE;
`ifdef SA_LOCK_TIMEOUT_EN
            cnt_q[o]   <= '0;
`endif
         end
         gnt_q  <= '0;
         busy_q <= '0;
      end else begin
         for (int o = 0; o < N; o++) begin
            st_q[o]    <= st_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
            ans_q[o]   <= ans_d[o];
`ifdef SA_LOCK_TIMEOUT_EN
            cnt_q[o]   <= cnt_d[o];
`endif
         end
         gnt_q  <= gnt_d;
         busy_q <= busy_d;
      end
   end

   assign sa.ans_R     = ans_q[0];
   assign sa.ans_L     = ans_q[1];
   assign sa.ans_U     = ans_q[2];
   assign sa.ans_D     = ans_q[3];
   assign sa.ans_EJ    = ans_q[4];
   assign sa.gnt       = gnt_q;
   assign sa.lock_busy = busy_q;

endmodule
